// File: rtl/fp_mant_booth_seq.sv
// rtl/fp_mant_booth_seq.sv - sequential radix-4 Booth multiplier for 24-bit FP mantissas
module fp_mant_booth_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [22:0] frc_X,
  input  logic [22:0] frc_Y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [47:0] frc_Z_full,
  output logic        busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state;
  logic [49:0] mcand;    // {1,frc_X} pre-shifted by 4^i for the current digit
  logic [26:0] mplier;   // {2'b00,1,frc_Y,0} shifted right two bits per digit
  logic [49:0] acc;
  logic [3:0]  cnt;
  logic [49:0] pp;
  logic [49:0] acc_next;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

  always_comb begin
    pp = '0;
    case (mplier[2:0])
      3'b001, 3'b010: pp = mcand;
      3'b011:         pp = {mcand[48:0], 1'b0};
      3'b100:         pp = ~{mcand[48:0], 1'b0} + 50'd1;
      3'b101, 3'b110: pp = ~mcand + 50'd1;
      default:        pp = '0;
    endcase
    acc_next = acc + pp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      cnt        <= '0;
      frc_Z_full <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            mcand  <= {26'd0, 1'b1, frc_X};
            mplier <= {2'b00, 1'b1, frc_Y, 1'b0};
            acc    <= '0;
            cnt    <= '0;
            state  <= S_CALC;
          end
        end
        S_CALC: begin
          acc    <= acc_next;
          mcand  <= {mcand[47:0], 2'b00};
          mplier <= {2'b00, mplier[26:2]};
          cnt    <= cnt + 4'd1;
          if (cnt == 4'd12) begin
            // Result register only moves here so it holds across the next operation
            frc_Z_full <= acc_next[47:0];
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mant_booth_seq.sv
// tb/tb_fp_mant_booth_seq.sv - scoreboard bench for fp_mant_booth_seq
module tb_fp_mant_booth_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [22:0] frc_X;
  logic [22:0] frc_Y;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] frc_Z_full;
  logic        busy;

  int          n_err = 0;
  int          n_chk = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  logic [47:0] last_z = '0;
  logic [47:0] exp_q[$];

  fp_mant_booth_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .frc_X(frc_X), .frc_Y(frc_Y), .out_valid(out_valid), .out_ready(out_ready),
    .frc_Z_full(frc_Z_full), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [47:0] model(input logic [22:0] x, input logic [22:0] y);
    logic [47:0] a;
    logic [47:0] b;
    a = {24'd0, 1'b1, x};
    b = {24'd0, 1'b1, y};
    return a * b;
  endfunction

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at #1 after an edge; returns at #1 after the accepting edge
  task automatic issue(input string tag, input logic [22:0] x, input logic [22:0] y);
    int w;
    w = 0;
    while (!in_ready && w < 40) begin
      @(posedge clk); #1; w++;
    end
    chk_bit({tag, "_in_ready"}, in_ready, 1'b1);
    in_valid = 1'b1; frc_X = x; frc_Y = y;
    @(posedge clk); #1;
    in_valid = 1'b0; frc_X = 23'($urandom); frc_Y = 23'($urandom);
    exp_q.push_back(model(x, y));
    acc_cyc = cyc;
    chk_bit({tag, "_busy"}, busy, 1'b1);
  endtask

  task automatic get_result(input string tag, input bit noisy);
    int w;
    logic [47:0] e;
    w = 0;
    while (!out_valid && w < 40) begin
      if (noisy) begin
        in_valid = 1'($urandom); out_ready = 1'($urandom);
        frc_X = 23'($urandom); frc_Y = 23'($urandom);
      end
      @(posedge clk); #1; w++;
      if (!out_valid) chk_w({tag, "_z_held"}, frc_Z_full, last_z);
    end
    in_valid = 1'b0;
    chk_bit({tag, "_out_valid"}, out_valid, 1'b1);
    if (out_valid) begin
      chk_w({tag, "_latency"}, 48'(cyc - acc_cyc), 48'd13);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 48'hx;
      chk_w({tag, "_product"}, frc_Z_full, e);
      chk_bit({tag, "_msb_norm"}, frc_Z_full[47] | frc_Z_full[46], 1'b1);
      last_z = e;
    end
  endtask

  task automatic handoff(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk_bit({tag, "_ov_low"}, out_valid, 1'b0);
    chk_bit({tag, "_in_ready"}, in_ready, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; frc_X = '0; frc_Y = '0;
    @(posedge clk); #1;
    chk_bit("rst_in_ready", in_ready, 1'b1);
    chk_bit("rst_out_valid", out_valid, 1'b0);
    chk_bit("rst_busy", busy, 1'b0);
    chk_w("rst_z", frc_Z_full, 48'h0);

    // 1.0 x 1.0, accepted on the very first edge after reset release
    in_valid = 1'b1; frc_X = 23'h0; frc_Y = 23'h0; out_ready = 1'b1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_q.push_back(48'h4000_0000_0000);
    acc_cyc = cyc;
    chk_bit("first_accept_busy", busy, 1'b1);
    get_result("one_x_one", 1'b0);
    handoff("one_x_one");

    issue("p15", 23'h400000, 23'h400000);
    chk_w("p15_const", exp_q[0], 48'h9000_0000_0000);
    get_result("p15", 1'b0);
    handoff("p15");

    issue("pmax", 23'h7FFFFF, 23'h7FFFFF);
    chk_w("pmax_const", exp_q[0], 48'hFFFF_FE00_0001);
    get_result("pmax", 1'b0);

    // Backpressure: five stalled cycles then handoff
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk_bit("bp_out_valid", out_valid, 1'b1);
      chk_w("bp_z", frc_Z_full, 48'hFFFF_FE00_0001);
      chk_bit("bp_in_ready", in_ready, 1'b0);
    end
    handoff("bp");

    // Reset in the middle of CALC
    issue("abort", 23'h123456, 23'h654321);
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk_bit("arst_in_ready", in_ready, 1'b1);
    chk_bit("arst_out_valid", out_valid, 1'b0);
    chk_bit("arst_busy", busy, 1'b0);
    chk_w("arst_z", frc_Z_full, 48'h0);
    void'(exp_q.pop_front());
    last_z = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    begin
      bit seen;
      seen = 1'b0;
      repeat (20) begin
        @(posedge clk); #1;
        if (out_valid) seen = 1'b1;
      end
      chk_bit("abort_no_out_valid", seen, 1'b0);
    end
    issue("post_rst", 23'h0, 23'h400000);
    chk_w("post_rst_const", exp_q[0], 48'h6000_0000_0000);
    get_result("post_rst", 1'b0);
    handoff("post_rst");

    // Random pairs with noisy ignored inputs and random backpressure
    for (int n = 0; n < 20; n++) begin
      int gap;
      int bp;
      gap = $urandom_range(0, 3);
      repeat (gap) begin @(posedge clk); #1; end
      issue("rnd", 23'($urandom), 23'($urandom));
      get_result("rnd", 1'b1);
      out_ready = 1'b0;
      bp = $urandom_range(0, 3);
      repeat (bp) begin
        @(posedge clk); #1;
        chk_bit("rnd_bp_valid", out_valid, 1'b1);
        chk_w("rnd_bp_z", frc_Z_full, last_z);
      end
      handoff("rnd");
    end

    chk_bit("queue_empty", exp_q.size() == 0, 1'b1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
